mips_alu_seq: RTL and testbench
===============================

// Module: mips_alu_seq
// PURPOSE
//  Execute-stage ALU that consumes the 3-bit ALUControl code from the ALU decoder.
//  AND/OR/ADD/SUB/SLT complete in one cycle; MUL (code 101) runs as an iterative
//  shift-add multiplier over WIDTH cycles. A Start/Busy/Done handshake lets the
//  multicycle controller stall while a multiply is in flight.
// PARAMETERS
//  WIDTH   32   operand/result width in bits (>=4)
// PORTS
//  CLK          in   1      clock; all state on rising edge
//  RST          in   1      synchronous, active-high reset
//  Start        in   1      request; accepted only when Busy==0
//  ALUControl   in   3      000 AND, 001 OR, 010 ADD, 100 SUB, 110 SLT, 101 MUL
//  SrcA         in   WIDTH  operand A
//  SrcB         in   WIDTH  operand B
//  ALUResult    out  WIDTH  registered result; held until next completion
//  Zero         out  1      registered (ALUResult==0), updated with ALUResult
//  Busy         out  1      high while a MUL iterates
//  Done         out  1      one-cycle pulse; ALUResult/Zero valid in that cycle
// BEHAVIOUR
//  Reset: state IDLE; ALUResult=0, Zero=1, Busy=0, Done=0, counter=0.
//   Reset mid-MUL aborts the operation; no Done is issued for it.
//  FSM: IDLE -> (Start & code==101) MUL -> (count==WIDTH-1) FIN -> IDLE.
//   IDLE, (Start & code!=101): result written at next edge, Done=1 next cycle,
//   state stays IDLE (latency 1).
//  Operands and code are latched on acceptance; later input changes do not affect
//   the operation in flight.
//  Arithmetic: ADD/SUB modulo 2^WIDTH, no overflow flag. SLT is a signed
//   two's-complement compare -> {0..0,1} or 0. Codes 011/111 -> result 0, Done still
//   pulses after 1 cycle.
//  MUL: Start accepted at cycle t; Busy=1 in cycles t+1..t+WIDTH; one multiplier bit
//   per cycle; ALUResult = low WIDTH bits of the product, Done=1 at cycle t+WIDTH+1
//   (state FIN), Busy=0 in that cycle. Low half is the same for signed and unsigned.
//  Start while Busy=1 is ignored; no queueing.
//  Start in the Done/FIN cycle is accepted (back-to-back issue).
//  Done never asserts in two consecutive cycles for a single MUL. Consecutive
//   single-cycle ops give one Done per op.
// CONFIGURATION
//  MIPS_ALU_MULHI_EN defined: adds output ALUResultHi [WIDTH-1:0], the upper half of
//   the signed 2*WIDTH product. Updated only on MUL completion; reset 0.
//   Non-MUL ops leave it unchanged.
//  Not defined: port absent; only the low half is kept; MUL latency is unchanged.
// TESTING
//  1 ADD 5+7, Start 1 cycle -> next cycle ALUResult=12, Zero=0, Done=1, Busy=0.
//  2 SUB 9-9 -> ALUResult=0, Zero=1. SLT A=0xFFFFFFFF, B=1 -> 1.
//    SLT A=1, B=0xFFFFFFFF -> 0.
//  3 MUL 6*(-3) at t -> Busy t+1..t+32, Done at t+33, ALUResult=0xFFFFFFEE.
//    ALUResultHi=0xFFFFFFFF if MIPS_ALU_MULHI_EN.
//  4 During test-3 MUL, Start ADD at t+5 -> ignored; exactly one Done, at t+33.
//  5 RST at t+10 of a MUL -> next cycle all outputs at reset values; no Done.
//    A following ADD 1+1 gives 2.
//  6 Start ADD 2+3 in the Done cycle of a MUL -> accepted; Done again next cycle
//    with ALUResult=5.

Source files
------------

// File: rtl/mips_alu_seq.sv
// Execute-stage ALU: single-cycle AND/OR/ADD/SUB/SLT plus an iterative WIDTH-cycle MUL.
// Define MIPS_ALU_MULHI_EN to add ALUResultHi (upper half of the signed product).
module mips_alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             Busy,
`ifdef MIPS_ALU_MULHI_EN
    output logic [WIDTH-1:0] ALUResultHi,
`endif
    output logic             Done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        FIN  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b100,
        OP_SLT = 3'b110,
        OP_MUL = 3'b101
    } alu_op_t;

`ifdef MIPS_ALU_MULHI_EN
    localparam int PW = 2 * WIDTH;
`else
    localparam int PW = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    count;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [PW-1:0]    acc_next;
    logic [PW-1:0]    partial;
    logic [WIDTH-1:0] alu_out;

    always_comb begin
        alu_out = '0;
        case (ALUControl)
            OP_AND:  alu_out = SrcA & SrcB;
            OP_OR:   alu_out = SrcA | SrcB;
            OP_ADD:  alu_out = SrcA + SrcB;
            OP_SUB:  alu_out = SrcA - SrcB;
            OP_SLT:  alu_out = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            default: alu_out = '0;
        endcase
    end

    // Multiplier MSB carries weight -2^(WIDTH-1), so the final step subtracts;
    // this yields the signed product, whose low half equals the unsigned one.
    always_comb begin
        partial  = mplier[0] ? mcand : '0;
        acc_next = (count == LAST) ? (acc - partial) : (acc + partial);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            count     <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            ALUResult <= '0;
            Zero      <= 1'b1;
            Busy      <= 1'b0;
            Done      <= 1'b0;
`ifdef MIPS_ALU_MULHI_EN
            ALUResultHi <= '0;
`endif
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE, FIN: begin
                    state <= IDLE;
                    if (Start) begin
                        if (ALUControl == OP_MUL) begin
                            state  <= MUL;
                            Busy   <= 1'b1;
                            count  <= '0;
                            acc    <= '0;
                            mcand  <= PW'($signed(SrcA));
                            mplier <= SrcB;
                        end else begin
                            ALUResult <= alu_out;
                            Zero      <= (alu_out == '0);
                            Done      <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    if (count == LAST) begin
                        state     <= FIN;
                        Busy      <= 1'b0;
                        Done      <= 1'b1;
                        ALUResult <= acc_next[WIDTH-1:0];
                        Zero      <= (acc_next[WIDTH-1:0] == '0);
`ifdef MIPS_ALU_MULHI_EN
                        ALUResultHi <= acc_next[PW-1:WIDTH];
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_alu_seq.sv
// Self-checking bench for mips_alu_seq: directed cases plus randomized ops
// against a plain-arithmetic reference model.
module tb_mips_alu_seq;

    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RST;
    logic         Start;
    logic [2:0]   ALUControl;
    logic [W-1:0] SrcA, SrcB;
    logic [W-1:0] ALUResult;
    logic         Zero, Busy, Done;
`ifdef MIPS_ALU_MULHI_EN
    logic [W-1:0] ALUResultHi;
`endif

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [W-1:0] hi_exp = '0;

    mips_alu_seq #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .Start(Start), .ALUControl(ALUControl),
        .SrcA(SrcA), .SrcB(SrcB), .ALUResult(ALUResult), .Zero(Zero),
        .Busy(Busy),
`ifdef MIPS_ALU_MULHI_EN
        .ALUResultHi(ALUResultHi),
`endif
        .Done(Done)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_op(input logic [2:0] code, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        longint signed p;
        case (code)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b100:  return a - b;
            3'b110:  return ($signed(a) < $signed(b)) ? 1 : 0;
            3'b101: begin
                p = longint'($signed(a)) * longint'($signed(b));
                return p[W-1:0];
            end
            default: return '0;
        endcase
    endfunction

    function automatic logic [W-1:0] ref_hi(input logic [W-1:0] a, input logic [W-1:0] b);
        longint signed p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p[2*W-1:W];
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_hi(input string tag);
`ifdef MIPS_ALU_MULHI_EN
        chk(tag, ALUResultHi, hi_exp);
`endif
    endtask

    // Single-cycle op: issue for one cycle, expect Done with result next cycle.
    task automatic run_op(input string tag, input logic [2:0] code, input logic [W-1:0] a,
                          input logic [W-1:0] b);
        logic [W-1:0] exp;
        exp = ref_op(code, a, b);
        Start = 1'b1; ALUControl = code; SrcA = a; SrcB = b;
        tick();
        Start = 1'b0; SrcA = $urandom; SrcB = $urandom;
        chk({tag, "_done"}, Done, 1'b1);
        chk({tag, "_busy"}, Busy, 1'b0);
        chk({tag, "_res"}, ALUResult, exp);
        chk({tag, "_zero"}, Zero, exp == '0);
        check_hi({tag, "_hi"});
    endtask

    // MUL: Busy for W cycles, Done in the following one. Optionally try an ADD at
    // t+5 (must be ignored) and/or issue ADD 2+3 in the Done cycle.
    task automatic run_mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit inject, input bit b2b);
        logic [W-1:0] exp;
        exp = ref_op(3'b101, a, b);
        Start = 1'b1; ALUControl = 3'b101; SrcA = a; SrcB = b;
        tick();
        for (int k = 1; k <= W; k++) begin
            Start = 1'b0; SrcA = $urandom; SrcB = $urandom;
            ALUControl = 3'($urandom_range(0, 7));
            if (inject && k == 5) begin
                Start = 1'b1; ALUControl = 3'b010;
            end
            chk({tag, "_busy"}, Busy, 1'b1);
            chk({tag, "_nodone"}, Done, 1'b0);
            tick();
        end
        Start = 1'b0;
        hi_exp = ref_hi(a, b);
        chk({tag, "_done"}, Done, 1'b1);
        chk({tag, "_busy_fin"}, Busy, 1'b0);
        chk({tag, "_res"}, ALUResult, exp);
        chk({tag, "_zero"}, Zero, exp == '0);
        check_hi({tag, "_hi"});
        if (b2b) begin
            run_op({tag, "_b2b"}, 3'b010, 32'd2, 32'd3);
        end else begin
            tick();
            chk({tag, "_done_once"}, Done, 1'b0);
        end
    endtask

    initial begin
        RST = 1'b1; Start = 1'b0; ALUControl = '0; SrcA = '0; SrcB = '0;
        tick(); tick();
        chk("rst_res", ALUResult, 32'd0);
        chk("rst_zero", Zero, 1'b1);
        chk("rst_busy", Busy, 1'b0);
        chk("rst_done", Done, 1'b0);
        check_hi("rst_hi");
        RST = 1'b0;
        tick();

        run_op("add", 3'b010, 32'd5, 32'd7);
        run_op("sub", 3'b100, 32'd9, 32'd9);
        run_op("slt_neg", 3'b110, 32'hFFFFFFFF, 32'd1);
        run_op("slt_pos", 3'b110, 32'd1, 32'hFFFFFFFF);
        run_op("and", 3'b000, 32'hF0F0_1234, 32'h0FF0_FFFF);
        run_op("or", 3'b001, 32'h8000_0001, 32'h0000_0100);
        run_op("op011", 3'b011, 32'h1234, 32'h5678);
        run_op("op111", 3'b111, 32'hFFFF, 32'h1);
        run_op("add_wrap", 3'b010, 32'hFFFF_FFFF, 32'd1);
        tick();
        chk("idle_done", Done, 1'b0);

        run_mul("mul_inj", 32'd6, 32'hFFFF_FFFD, 1'b1, 1'b0);
        run_mul("mul_b2b", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
        run_op("add_after_mul", 3'b010, 32'd10, 32'd20);

        // Reset in cycle t+10 of a MUL aborts it with no Done.
        Start = 1'b1; ALUControl = 3'b101; SrcA = 32'd7; SrcB = 32'd9;
        tick();
        Start = 1'b0;
        for (int k = 1; k < 10; k++) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("abort_res", ALUResult, 32'd0);
        chk("abort_zero", Zero, 1'b1);
        chk("abort_busy", Busy, 1'b0);
        chk("abort_done", Done, 1'b0);
        hi_exp = '0;
        check_hi("abort_hi");
        for (int k = 0; k < W + 4; k++) begin
            tick();
            chk("abort_quiet", Done, 1'b0);
        end
        run_op("add_after_rst", 3'b010, 32'd1, 32'd1);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]   code;
            logic [W-1:0] a, b;
            code = 3'($urandom_range(0, 7));
            a = $urandom; b = (i % 5 == 0) ? a : $urandom;
            if (code == 3'b101) run_mul("rnd_mul", a, b, 1'b0, (i % 2) == 0);
            else run_op("rnd_op", code, a, b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
